// File: rtl/egc_encoder.sv
// Serial Exp-Golomb encoder: m ones, a zero separator, then the m-bit offset MSB-first,
// followed by GAP_CYCLES idle cycles so the downstream decoder's dead cycles never eat a bit.
module egc_encoder #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       so_data,
  output logic       so_active,
  output logic       done,
  output logic       err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, PREFIX, SEP, SUFFIX, GAP, ERR} state_t;

  state_t         state_q, state_d;
  logic [1:0]     m_q, m_d;
  logic [2:0]     off_q, off_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           err_q, err_d;

  logic [1:0]     mIn;
  logic [3:0]     offWide;
  logic [1:0]     bitIdx;

  // Prefix length and offset of the incoming value; only used on an accepting edge.
  always_comb begin
    mIn     = 2'd0;
    offWide = 4'd0;
    if (in_data == 4'd0) begin
      mIn     = 2'd0;
      offWide = 4'd0;
    end else if (in_data <= 4'd2) begin
      mIn     = 2'd1;
      offWide = in_data - 4'd1;
    end else if (in_data <= 4'd6) begin
      mIn     = 2'd2;
      offWide = in_data - 4'd3;
    end else begin
      mIn     = 2'd3;
      offWide = in_data - 4'd7;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 2'd0;
      off_q   <= 3'd0;
      cnt_q   <= 2'd0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from the registered state, so reset clears them immediately.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    err_d     = 1'b0;
    in_ready  = 1'b0;
    so_active = 1'b0;
    so_data   = 1'b0;
    done      = 1'b0;
    bitIdx    = cnt_q - 2'd1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == 4'd15) begin
            state_d = ERR;
          end else begin
            m_d     = mIn;
            off_d   = offWide[2:0];
            cnt_d   = mIn;
            state_d = (mIn == 2'd0) ? SEP : PREFIX;
          end
        end
      end
      PREFIX: begin
        so_active = 1'b1;
        so_data   = 1'b1;
        if (cnt_q == 2'd1) state_d = SEP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      SEP: begin
        so_active = 1'b1;
        if (m_q == 2'd0) begin
          done    = 1'b1;
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES);
        end else begin
          state_d = SUFFIX;
          cnt_d   = m_q;
        end
      end
      SUFFIX: begin
        so_active = 1'b1;
        so_data   = off_q[bitIdx];
        if (cnt_q == 2'd1) begin
          done    = 1'b1;
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES);
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      GAP: begin
        if (gap_q == GW'(1)) state_d = IDLE;
        else                 gap_d   = gap_q - GW'(1);
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_egc_encoder.sv
// Self-checking bench for egc_encoder: fixed vector table, corner sequences,
// and random values checked against an arithmetic Exp-Golomb model.
module tb_egc_encoder;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic [3:0] inData;
  logic       inReady, soData, soActive, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         v;
    logic [6:0] code;
    int         len;
  } vec_t;

  vec_t vecs[8];

  egc_encoder #(.GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_data  (inData),
    .in_ready (inReady),
    .so_data  (soData),
    .so_active(soActive),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Exp-Golomb model: m = floor(log2(v+1)); code = (2^m-1) ones, a zero, then v-(2^m-1) in m bits.
  task automatic modelCode(input int v, output logic [6:0] code, output int len);
    int m;
    int base;
    m = 0;
    while ((1 << (m + 1)) - 1 <= v) m++;
    base = (1 << m) - 1;
    len  = 2 * m + 1;
    code = 7'(((base << (m + 1)) | (v - base)));
  endtask

  task automatic applyStimulus(input int v, input logic [6:0] code, input int len, input string tag);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!inReady && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, "_ready_before"}, inReady, 1);
    inValid = 1'b1;
    inData  = 4'(v);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    inData  = 4'($urandom_range(0, 15));
    if (v == 15) begin
      checkOutput({tag, "_err_e0"}, err, 0);
      checkOutput({tag, "_ready_e0"}, inReady, 0);
      checkOutput({tag, "_act_e0"}, soActive, 0);
      @(negedge clk);
      checkOutput({tag, "_err_e1"}, err, 1);
      checkOutput({tag, "_ready_e1"}, inReady, 1);
      checkOutput({tag, "_act_e1"}, soActive, 0);
      checkOutput({tag, "_done_e1"}, done, 0);
      @(negedge clk);
      checkOutput({tag, "_err_e2"}, err, 0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      checkOutput({tag, "_act"}, soActive, 1);
      checkOutput({tag, "_bit"}, soData, code[len - 1 - i]);
      checkOutput({tag, "_done"}, done, (i == len - 1) ? 1 : 0);
      checkOutput({tag, "_ready_busy"}, inReady, 0);
      checkOutput({tag, "_err"}, err, 0);
      @(negedge clk);
    end
    for (int g = 0; g < GAP; g++) begin
      checkOutput({tag, "_gap_act"}, soActive, 0);
      checkOutput({tag, "_gap_data"}, soData, 0);
      checkOutput({tag, "_gap_ready"}, inReady, 0);
      checkOutput({tag, "_gap_done"}, done, 0);
      @(negedge clk);
    end
    checkOutput({tag, "_ready_after"}, inReady, 1);
  endtask

  initial begin
    int expAct[15];
    int expDat[15];
    int firstReady;
    logic [6:0] mCode;
    int mLen;
    int v;

    rst     = 1'b1;
    inValid = 1'b0;
    inData  = 4'd0;
    #2;
    checkOutput("reset_ready", inReady, 1);
    checkOutput("reset_act", soActive, 0);
    checkOutput("reset_data", soData, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{0,  7'b0000000, 1};
    vecs[1] = '{5,  7'b0011010, 5};
    vecs[2] = '{14, 7'b1110111, 7};
    vecs[3] = '{7,  7'b1110000, 7};
    vecs[4] = '{1,  7'b0000100, 3};
    vecs[5] = '{2,  7'b0000101, 3};
    vecs[6] = '{15, 7'b0000000, 0};
    vecs[7] = '{12, 7'b1110101, 7};
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k].v, vecs[k].code, vecs[k].len, $sformatf("vec%0d_v%0d", k, vecs[k].v));
    end

    // Back-to-back accepts with in_valid held high; second accept must be 8 cycles after the first.
    expAct = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    expDat = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0};
    firstReady = -1;
    @(negedge clk);
    checkOutput("b2b_ready_start", inReady, 1);
    inValid = 1'b1;
    inData  = 4'd3;
    @(posedge clk);
    #1 inData = 4'd6;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_act_c%0d", c), soActive, expAct[c]);
      checkOutput($sformatf("b2b_data_c%0d", c), soData, expDat[c]);
      if (inReady && firstReady < 0) firstReady = c;
    end
    inValid = 1'b0;
    checkOutput("b2b_reaccept_cycle", firstReady, 7);
    @(negedge clk);
    checkOutput("b2b_ready_end", inReady, 1);

    for (int r = 0; r < 40; r++) begin
      v = $urandom_range(0, 15);
      modelCode(v, mCode, mLen);
      applyStimulus(v, mCode, mLen, $sformatf("rnd%0d_v%0d", r, v));
    end

    // Reset during the third bit of v=12 must abort the code asynchronously.
    @(negedge clk);
    checkOutput("rst_ready_start", inReady, 1);
    inValid = 1'b1;
    inData  = 4'd12;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_bit3_act", soActive, 1);
    checkOutput("rst_bit3_data", soData, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_act", soActive, 0);
    checkOutput("rst_async_data", soData, 0);
    checkOutput("rst_async_ready", inReady, 1);
    checkOutput("rst_async_done", done, 0);
    checkOutput("rst_async_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_release_act", soActive, 0);
    @(negedge clk);
    checkOutput("rst_after_act", soActive, 0);
    applyStimulus(4, 7'b0011001, 5, "post_rst_v4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
